// File: rtl/ant_sym_framer.sv
// Antenna-data framer: 2-entry skid buffer that tags each beat with RE/symbol position,
// plus a periodic IQ tx-enable strobe that starts after a programmable delay.
module ant_sym_framer #(
  parameter int LANES        = 8,
  parameter int ANTS         = 4,
  parameter int IQ_W         = 32,
  parameter int RE_PER_SYM   = 1584,
  parameter int SYM_PER_SLOT = 14,
  parameter int START_DLY    = 100,
  parameter int TX_PERIOD    = 96,
  parameter int AW           = 11
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_enable,
  input  logic [LANES*ANTS*IQ_W-1:0]  i_data,
  input  logic                        i_vld,
  input  logic                        i_sof,
  output logic                        o_rdy,
  output logic [LANES*ANTS*IQ_W-1:0]  o_data,
  output logic                        o_vld,
  input  logic                        i_rready,
  output logic [AW-1:0]               o_re_addr,
  output logic                        o_re_last,
  output logic [3:0]                  o_sym_idx,
  output logic                        o_slot_last,
  output logic                        o_tx_en,
  output logic                        o_ovf,
  input  logic                        i_ovf_clr
);

  localparam int DW    = LANES * ANTS * IQ_W;
  localparam int SW    = 4;
  localparam int DLY_W = (START_DLY > 1) ? $clog2(START_DLY) : 1;
  localparam int PER_W = (TX_PERIOD > 1) ? $clog2(TX_PERIOD) : 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] re;
    logic [SW-1:0] sym;
    logic          re_last;
    logic          slot_last;
  } beat_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_t;
  typedef enum logic [1:0] {IDLE, DELAY, RUN} timer_t;

  skid_t         skid, skid_nxt;
  timer_t        timer;
  beat_t         in_beat, head, hold;
  logic [AW-1:0] re_cnt, tag_re;
  logic [SW-1:0] sym_cnt, tag_sym;
  logic          accept, consume, tag_re_last;
  logic          enable_q, tx_en, ovf;
  logic [DLY_W-1:0] dly_cnt;
  logic [PER_W-1:0] per_cnt;

  assign accept      = i_vld & o_rdy;
  assign consume     = o_vld & i_rready;
  assign tag_re      = i_sof ? '0 : re_cnt;
  assign tag_sym     = i_sof ? '0 : sym_cnt;
  assign tag_re_last = (tag_re == AW'(RE_PER_SYM - 1));

  assign in_beat = '{data:      i_data,
                     re:        tag_re,
                     sym:       tag_sym,
                     re_last:   tag_re_last,
                     slot_last: tag_re_last && (tag_sym == SW'(SYM_PER_SLOT - 1))};

  assign o_data      = head.data;
  assign o_re_addr   = head.re;
  assign o_sym_idx   = head.sym;
  assign o_re_last   = head.re_last;
  assign o_slot_last = head.slot_last;
  assign o_tx_en     = tx_en;
  assign o_ovf       = ovf;

  // Position of the next accepted beat; a sof beat is tagged 0/0 so its successor lands on RE 1.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      re_cnt  <= '0;
      sym_cnt <= '0;
    end else if (accept) begin
      if (tag_re_last) begin
        re_cnt  <= '0;
        sym_cnt <= (tag_sym == SW'(SYM_PER_SLOT - 1)) ? '0 : tag_sym + 1'b1;
      end else begin
        re_cnt  <= tag_re + 1'b1;
        sym_cnt <= tag_sym;
      end
    end
  end

  always_comb begin
    skid_nxt = skid;
    case (skid)
      EMPTY:   if (accept) skid_nxt = ONE;
      ONE:     if (accept && !consume) skid_nxt = TWO;
               else if (!accept && consume) skid_nxt = EMPTY;
      TWO:     if (consume) skid_nxt = ONE;
      default: skid_nxt = EMPTY;
    endcase
  end

  // head drives the outputs directly; hold only fills while the head is stalled.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      skid  <= EMPTY;
      head  <= '0;
      hold  <= '0;
      o_vld <= 1'b0;
      o_rdy <= 1'b0;
    end else begin
      skid  <= skid_nxt;
      o_vld <= (skid_nxt != EMPTY);
      o_rdy <= i_enable && (skid_nxt != TWO);
      case (skid)
        EMPTY: if (accept) head <= in_beat;
        ONE: begin
          if (accept && consume) head <= in_beat;
          else if (accept)       hold <= in_beat;
        end
        TWO:     if (consume) head <= hold;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)               ovf <= 1'b0;
    else if (i_vld && !o_rdy)     ovf <= 1'b1;
    else if (i_ovf_clr)           ovf <= 1'b0;
  end

  // Timer runs from the registered enable so that any enable drop restarts the whole delay.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      enable_q <= 1'b0;
      timer    <= IDLE;
      dly_cnt  <= '0;
      per_cnt  <= '0;
      tx_en    <= 1'b0;
    end else begin
      enable_q <= i_enable;
      tx_en    <= 1'b0;
      if (!enable_q) begin
        timer   <= IDLE;
        dly_cnt <= '0;
        per_cnt <= '0;
      end else begin
        case (timer)
          IDLE: begin
            timer   <= DELAY;
            dly_cnt <= '0;
          end
          DELAY: begin
            if (dly_cnt == DLY_W'(START_DLY - 1)) begin
              timer   <= RUN;
              per_cnt <= '0;
            end else begin
              dly_cnt <= dly_cnt + 1'b1;
            end
          end
          RUN: begin
            if (per_cnt == PER_W'(TX_PERIOD - 1)) begin
              per_cnt <= '0;
              tx_en   <= 1'b1;
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end
          default: timer <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ant_sym_framer.sv
// Self-checking bench for ant_sym_framer: directed steps plus a random phase,
// every cycle compared against a queue/arithmetic reference model.
module tb_ant_sym_framer;

  localparam int LANES        = 8;
  localparam int ANTS         = 4;
  localparam int IQ_W         = 32;
  localparam int RE_PER_SYM   = 1584;
  localparam int SYM_PER_SLOT = 14;
  localparam int START_DLY    = 100;
  localparam int TX_PERIOD    = 96;
  localparam int AW           = 11;
  localparam int DW           = LANES * ANTS * IQ_W;
  localparam int FIRST_TX     = START_DLY + TX_PERIOD + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0, vld = 1'b0, sof = 1'b0, rready = 1'b0, ovf_clr = 1'b0;
  logic [DW-1:0] data = '0;
  logic          o_rdy, o_vld, o_re_last, o_slot_last, o_tx_en, o_ovf;
  logic [DW-1:0] o_data;
  logic [AW-1:0] o_re_addr;
  logic [3:0]    o_sym_idx;

  ant_sym_framer #(
    .LANES(LANES), .ANTS(ANTS), .IQ_W(IQ_W), .RE_PER_SYM(RE_PER_SYM),
    .SYM_PER_SLOT(SYM_PER_SLOT), .START_DLY(START_DLY), .TX_PERIOD(TX_PERIOD), .AW(AW)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable), .i_data(data), .i_vld(vld),
    .i_sof(sof), .o_rdy(o_rdy), .o_data(o_data), .o_vld(o_vld), .i_rready(rready),
    .o_re_addr(o_re_addr), .o_re_last(o_re_last), .o_sym_idx(o_sym_idx),
    .o_slot_last(o_slot_last), .o_tx_en(o_tx_en), .o_ovf(o_ovf), .i_ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            re;
    int            sym;
  } beat_t;

  beat_t exp_q[$];
  int    pos, run_len, edge_cnt, first_tx;
  int    tests, errors, consumed, re_last_seen, slot_hits, slot_last_idx;
  logic  m_rdy, m_ovf, m_tx;

  function automatic logic [DW-1:0] randBeat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic resetModel();
    exp_q.delete();
    pos      = 0;
    run_len  = 0;
    m_rdy    = 1'b0;
    m_ovf    = 1'b0;
    m_tx     = 1'b0;
    edge_cnt = 0;
    first_tx = -1;
  endtask

  task automatic expectEq(input string tag, input logic [127:0] got, input logic [127:0] want);
    tests++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic checkOutput();
    if (!reset_n) begin
      expectEq("rst_vld", o_vld, 0);
      expectEq("rst_rdy", o_rdy, 0);
      expectEq("rst_data", 128'(o_data != '0), 0);
      expectEq("rst_re", o_re_addr, 0);
      expectEq("rst_sym", o_sym_idx, 0);
      expectEq("rst_flags", {o_re_last, o_slot_last}, 0);
      expectEq("rst_tx", o_tx_en, 0);
      expectEq("rst_ovf", o_ovf, 0);
    end else begin
      expectEq("rdy", o_rdy, m_rdy);
      expectEq("vld", o_vld, exp_q.size() > 0);
      expectEq("ovf", o_ovf, m_ovf);
      expectEq("tx_en", o_tx_en, m_tx);
      if (exp_q.size() > 0) begin
        tests++;
        assert (o_data === exp_q[0].data) else begin
          errors++;
          $error("[TB] FAIL data: observed %0h expected %0h (low 128 bits)",
                 o_data[127:0], exp_q[0].data[127:0]);
        end
        expectEq("re_addr", o_re_addr, exp_q[0].re);
        expectEq("sym_idx", o_sym_idx, exp_q[0].sym);
        expectEq("re_last", o_re_last, exp_q[0].re == RE_PER_SYM - 1);
        expectEq("slot_last", o_slot_last,
                 (exp_q[0].re == RE_PER_SYM - 1) && (exp_q[0].sym == SYM_PER_SLOT - 1));
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic r,
                               input logic e, input logic c);
    bit    acc, cons;
    beat_t b;
    vld = v; sof = s; rready = r; enable = e; ovf_clr = c;
    data = randBeat();
    if (reset_n && o_vld && r) begin
      if (o_re_last) re_last_seen++;
      if (o_slot_last) begin
        slot_hits++;
        slot_last_idx = consumed;
      end
    end
    @(posedge clk);
    if (reset_n) begin
      acc  = v && m_rdy;
      cons = (exp_q.size() > 0) && r;
      if (cons) begin
        void'(exp_q.pop_front());
        consumed++;
      end
      if (acc) begin
        if (s) pos = 0;
        b.data = data;
        b.re   = pos % RE_PER_SYM;
        b.sym  = pos / RE_PER_SYM;
        exp_q.push_back(b);
        pos = (pos + 1) % (RE_PER_SYM * SYM_PER_SLOT);
      end
      if (v && !m_rdy) m_ovf = 1'b1;
      else if (c)      m_ovf = 1'b0;
      m_tx    = (run_len >= FIRST_TX) && ((run_len - FIRST_TX) % TX_PERIOD == 0);
      run_len = e ? run_len + 1 : 0;
      m_rdy   = e && (exp_q.size() < 2);
      edge_cnt++;
    end
    #1;
    if (reset_n && o_tx_en && first_tx < 0) first_tx = edge_cnt - 1;
    checkOutput();
  endtask

  initial begin
    int guard, t5_first;
    tests = 0; errors = 0; consumed = 0; re_last_seen = 0; slot_hits = 0; slot_last_idx = -1;
    resetModel();

    #1 reset_n = 1'b0;
    #1 checkOutput();
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    enable  = 1'b1;

    // Back-to-back stream, two full symbols
    applyStimulus(0, 0, 1, 1, 0);
    guard = 0;
    while (consumed < 2 * RE_PER_SYM && guard < 5000) begin
      applyStimulus(1, 0, 1, 1, 0);
      guard++;
    end
    expectEq("stream1_timeout", guard < 5000, 1);
    expectEq("re_last_count", re_last_seen, 2);
    expectEq("first_tx_edge", first_tx, FIRST_TX);

    // Full slot: slot_last on beat 22175 only
    guard = 0;
    while (consumed < RE_PER_SYM * SYM_PER_SLOT + 1 && guard < 25000) begin
      applyStimulus(1, 0, 1, 1, 0);
      guard++;
    end
    expectEq("stream2_timeout", guard < 25000, 1);
    expectEq("slot_last_hits", slot_hits, 1);
    expectEq("slot_last_beat", slot_last_idx, RE_PER_SYM * SYM_PER_SLOT - 1);

    // Backpressure fills the skid buffer without loss
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(1, 0, 0, 1, 0);
    expectEq("rdy_after_1", o_rdy, 1);
    applyStimulus(1, 0, 0, 1, 0);
    expectEq("rdy_after_2", o_rdy, 0);
    applyStimulus(0, 0, 0, 1, 0);
    expectEq("ovf_bp", o_ovf, 0);

    // Overflow: drop, clear, and set-beats-clear
    applyStimulus(1, 0, 0, 1, 0);
    expectEq("ovf_set", o_ovf, 1);
    applyStimulus(0, 0, 0, 1, 1);
    expectEq("ovf_clr", o_ovf, 0);
    applyStimulus(1, 0, 0, 1, 1);
    expectEq("ovf_set_wins", o_ovf, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 1);

    // Enable drop restarts the full tx delay
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0);
    t5_first = -1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 0, 1, 1, 0);
      if (o_tx_en && t5_first < 0) t5_first = i;
    end
    expectEq("tx_after_reenable", t5_first, FIRST_TX);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      applyStimulus(($urandom % 4) != 0, ($urandom % 64) == 0, ($urandom % 3) != 0,
                    ($urandom % 32) != 0, ($urandom % 8) == 0);

    // sof at RE 700 realigns to 0/0
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 1);
    guard = 0;
    while ((pos % RE_PER_SYM) != 700 && guard < 3000) begin
      applyStimulus(1, 0, 1, 1, 0);
      guard++;
    end
    expectEq("reach700_timeout", guard < 3000, 1);
    applyStimulus(1, 1, 1, 1, 0);
    expectEq("sof_vld", o_vld, 1);
    expectEq("sof_re", o_re_addr, 0);
    expectEq("sof_sym", o_sym_idx, 0);
    applyStimulus(1, 0, 1, 1, 0);
    expectEq("post_sof_re", o_re_addr, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, ($urandom % 2) != 0, 1, 0);

    // Mid-slot async reset
    reset_n = 1'b0;
    #1;
    resetModel();
    checkOutput();
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    reset_n = 1'b1;
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(1, 0, 1, 1, 0);
    expectEq("post_rst_vld", o_vld, 1);
    expectEq("post_rst_re", o_re_addr, 0);
    expectEq("post_rst_sym", o_sym_idx, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
